// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game controller and the pixel renderer.
// Holds the screen/object geometry, the bounds derived from it, game rules
// (speeds, winning score, serve delay), the controller state encoding and a
// few small arithmetic helpers.
package pong_pkg;

    // Screen and object geometry, shared with the renderer
    localparam logic [10:0] H_ACTIVE     = 11'd1280;
    localparam logic [10:0] V_ACTIVE     = 11'd720;
    localparam logic [10:0] PADDLE_H     = 11'd100;
    localparam logic [10:0] PADDLE_W     = 11'd12;
    localparam logic [10:0] BALL_S       = 11'd10;
    localparam logic [10:0] BORDER       = 11'd8;
    localparam logic [10:0] P1_X         = 11'd40;
    localparam logic [10:0] P2_X         = H_ACTIVE - 11'd40 - PADDLE_W;      // 1228

    // Game rules
    localparam logic [10:0] PADDLE_SPEED = 11'd6;
    localparam logic [10:0] BALL_SPEED   = 11'd4;
    localparam logic [3:0]  WIN_SCORE    = 4'd9;
    localparam logic [5:0]  SERVE_FRAMES = 6'd60;

    // Derived bounds
    localparam logic [10:0] P1_FACE_X    = P1_X + PADDLE_W;                   // 52
    localparam logic [10:0] P2_HIT_X     = P2_X - BALL_S;                     // 1218
    localparam logic [10:0] PADDLE_Y_MIN = BORDER;                            // 8
    localparam logic [10:0] PADDLE_Y_MAX = V_ACTIVE - BORDER - PADDLE_H;      // 612
    localparam logic [10:0] BALL_Y_MIN   = BORDER;                            // 8
    localparam logic [10:0] BALL_Y_MAX   = V_ACTIVE - BORDER - BALL_S;        // 702
    localparam logic [10:0] BOTTOM_EDGE  = V_ACTIVE - BORDER;                 // 712
    localparam logic [10:0] RIGHT_EDGE   = H_ACTIVE - BORDER;                 // 1272

    // Start-of-rally positions
    localparam logic [10:0] PADDLE_Y_RST = 11'd310;
    localparam logic [10:0] BALL_X_CTR   = 11'd635;
    localparam logic [10:0] BALL_Y_CTR   = 11'd355;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Zero-extend a screen coordinate into signed 12-bit space so that
    // stepping past the top/left edge yields a negative value, not a wrap.
    function automatic logic signed [11:0] to_s12(input logic [10:0] v);
        return signed'({1'b0, v});
    endfunction

    // Score increment that sticks at the winning score.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        logic [3:0] r;
        if (s >= WIN_SCORE) begin
            r = s;
        end else begin
            r = s + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle's vertical position.
// Ports: clk, rst (sync, active-high), tick (frame step), up/dn (button
// levels), en (movement allowed), y (registered paddle top edge).
// Up-only moves up, down-only moves down, both or neither hold; the result
// is clamped to the playfield between the borders.
module paddle_ctrl
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        up,
    input  logic        dn,
    input  logic        en,
    output logic [10:0] y
);

    logic [10:0]        y_r;
    logic [10:0]        y_next_s;
    logic signed [11:0] y_up_s;
    logic signed [11:0] y_dn_s;

    // Candidate position for this frame, clamped to the legal range
    always_comb begin
        y_up_s   = to_s12(y_r) - to_s12(PADDLE_SPEED);
        y_dn_s   = to_s12(y_r) + to_s12(PADDLE_SPEED);
        y_next_s = y_r;
        if (up && !dn) begin
            if (y_up_s < to_s12(PADDLE_Y_MIN)) begin
                y_next_s = PADDLE_Y_MIN;
            end else begin
                y_next_s = y_up_s[10:0];
            end
        end else if (dn && !up) begin
            if (y_dn_s > to_s12(PADDLE_Y_MAX)) begin
                y_next_s = PADDLE_Y_MAX;
            end else begin
                y_next_s = y_dn_s[10:0];
            end
        end else begin
            y_next_s = y_r;
        end
    end

    // Position register, stepped once per enabled frame
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r <= PADDLE_Y_RST;
        end else if (tick && en) begin
            y_r <= y_next_s;
        end
    end

    assign y = y_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong game controller: paddles, ball physics, scores and the
// IDLE/SERVE/PLAY/OVER sequence, stepping once per frame_tick.
// Ports: clk, rst (sync, active-high), frame_tick (one pulse per frame),
// start (level), p1_up/p1_dn/p2_up/p2_dn (button levels);
// outputs p1_y/p2_y (paddle tops), ball_x/ball_y (ball top-left),
// score_l/score_r, game_over. All outputs are registered and change only on
// frame ticks (or on a start-driven state change), so a frame never tears.
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    output logic [10:0] p1_y,
    output logic [10:0] p2_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    state_e             state_r, state_s;
    logic [10:0]        ball_x_r, ball_x_s, ball_y_r, ball_y_s;
    logic               dx_neg_r, dx_neg_s, dy_neg_r, dy_neg_s;
    logic [3:0]         score_l_r, score_l_s, score_r_r, score_r_s;
    logic [5:0]         serve_cnt_r, serve_cnt_s;
    logic               game_over_r;
    logic               paddle_en_s;
    logic signed [11:0] step_x_s, step_y_s, nx_s, ny_s;
    logic               ovl_l_s, ovl_r_s, hit_l_s, hit_r_s;

    assign paddle_en_s = (state_r != ST_OVER);

    paddle_ctrl u_paddle_l (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .up   (p1_up),
        .dn   (p1_dn),
        .en   (paddle_en_s),
        .y    (p1_y)
    );

    paddle_ctrl u_paddle_r (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .up   (p2_up),
        .dn   (p2_dn),
        .en   (paddle_en_s),
        .y    (p2_y)
    );

    // Proposed ball position and paddle-hit detection against pre-update values
    always_comb begin
        step_x_s = dx_neg_r ? -to_s12(BALL_SPEED) : to_s12(BALL_SPEED);
        step_y_s = dy_neg_r ? -to_s12(BALL_SPEED) : to_s12(BALL_SPEED);
        nx_s     = to_s12(ball_x_r) + step_x_s;
        ny_s     = to_s12(ball_y_r) + step_y_s;
        ovl_l_s  = ((ball_y_r + BALL_S) > p1_y) && (ball_y_r < (p1_y + PADDLE_H));
        ovl_r_s  = ((ball_y_r + BALL_S) > p2_y) && (ball_y_r < (p2_y + PADDLE_H));
        // Only a ball that was still in front of the paddle face can be hit
        hit_l_s  = dx_neg_r && (nx_s <= to_s12(P1_FACE_X))
                   && (ball_x_r >= P1_FACE_X) && ovl_l_s;
        hit_r_s  = !dx_neg_r && ((nx_s + to_s12(BALL_S)) >= to_s12(P2_X))
                   && ((ball_x_r + BALL_S) <= P2_X) && ovl_r_s;
    end

    // Next-state, ball, score and serve-counter logic
    always_comb begin
        state_s     = state_r;
        ball_x_s    = ball_x_r;
        ball_y_s    = ball_y_r;
        dx_neg_s    = dx_neg_r;
        dy_neg_s    = dy_neg_r;
        score_l_s   = score_l_r;
        score_r_s   = score_r_r;
        serve_cnt_s = serve_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SERVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    ball_x_s = BALL_X_CTR;
                    ball_y_s = BALL_Y_CTR;
                    if ((serve_cnt_r + 6'd1) == SERVE_FRAMES) begin
                        serve_cnt_s = 6'd0;
                        state_s     = ST_PLAY;
                    end else begin
                        serve_cnt_s = serve_cnt_r + 6'd1;
                    end
                end else begin
                    serve_cnt_s = serve_cnt_r;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    // Vertical: walls reflect and clamp
                    if (ny_s <= to_s12(BALL_Y_MIN)) begin
                        ball_y_s = BALL_Y_MIN;
                        dy_neg_s = 1'b0;
                    end else if ((ny_s + to_s12(BALL_S)) >= to_s12(BOTTOM_EDGE)) begin
                        ball_y_s = BALL_Y_MAX;
                        dy_neg_s = 1'b1;
                    end else begin
                        ball_y_s = ny_s[10:0];
                    end
                    // Horizontal: paddle hits first, then misses
                    if (hit_l_s) begin
                        ball_x_s = P1_FACE_X;
                        dx_neg_s = 1'b0;
                    end else if (hit_r_s) begin
                        ball_x_s = P2_HIT_X;
                        dx_neg_s = 1'b1;
                    end else if (nx_s <= to_s12(BORDER)) begin
                        // Left player missed: serve back toward the left
                        score_r_s = score_inc(score_r_r);
                        ball_x_s  = BALL_X_CTR;
                        ball_y_s  = BALL_Y_CTR;
                        dx_neg_s  = 1'b1;
                        state_s   = (score_r_s == WIN_SCORE) ? ST_OVER : ST_SERVE;
                    end else if ((nx_s + to_s12(BALL_S)) >= to_s12(RIGHT_EDGE)) begin
                        // Right player missed: serve back toward the right
                        score_l_s = score_inc(score_l_r);
                        ball_x_s  = BALL_X_CTR;
                        ball_y_s  = BALL_Y_CTR;
                        dx_neg_s  = 1'b0;
                        state_s   = (score_l_s == WIN_SCORE) ? ST_OVER : ST_SERVE;
                    end else begin
                        ball_x_s = nx_s[10:0];
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_l_s = 4'd0;
                    score_r_s = 4'd0;
                    state_s   = ST_SERVE;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Game state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ball_x_r    <= BALL_X_CTR;
            ball_y_r    <= BALL_Y_CTR;
            dx_neg_r    <= 1'b0;
            dy_neg_r    <= 1'b0;
            score_l_r   <= 4'd0;
            score_r_r   <= 4'd0;
            serve_cnt_r <= 6'd0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ball_x_r    <= ball_x_s;
            ball_y_r    <= ball_y_s;
            dx_neg_r    <= dx_neg_s;
            dy_neg_r    <= dy_neg_s;
            score_l_r   <= score_l_s;
            score_r_r   <= score_r_s;
            serve_cnt_r <= serve_cnt_s;
            game_over_r <= (state_s == ST_OVER);
        end
    end

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign score_l   = score_l_r;
    assign score_r   = score_r_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl. A single rally is played with
// hand-computed ball trajectories: right paddle bounce, left paddle bounce,
// left miss, mid-play reset, then nine right misses to reach game over.
module tb_pong_game_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic        p1_up, p1_dn, p2_up, p2_dn;
    logic [10:0] p1_y, p2_y, ball_x, ball_y;
    logic [3:0]  score_l, score_r;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    pong_game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // n back-to-back frame ticks; returns on the falling edge after the last
    task automatic ticks(input int n);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        if ({p1_y, p2_y} !== {11'd310, 11'd310}) begin $display("FAIL reset_paddles: got %0d,%0d want 310,310", p1_y, p2_y); failures++; end
        checks++;
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL reset_ball: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
        if ({score_l, score_r, game_over} !== {4'd0, 4'd0, 1'b0}) begin $display("FAIL reset_score: got %0d/%0d go=%0b want 0/0 go=0", score_l, score_r, game_over); failures++; end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_paddle_clamp;
        p1_up = 1'b1;
        repeat (5) @(negedge clk);
        if (p1_y !== 11'd310) begin $display("FAIL hold_between_ticks: p1_y=%0d want 310", p1_y); failures++; end
        checks++;
        ticks(50);
        if (p1_y !== 11'd10) begin $display("FAIL p1_up_50: p1_y=%0d want 10", p1_y); failures++; end
        checks++;
        ticks(10);
        if (p1_y !== 11'd8) begin $display("FAIL p1_clamp_top: p1_y=%0d want 8", p1_y); failures++; end
        checks++;
        p1_dn = 1'b1; p2_up = 1'b1; p2_dn = 1'b1;
        ticks(3);
        if ({p1_y, p2_y} !== {11'd8, 11'd310}) begin $display("FAIL both_buttons: got %0d,%0d want 8,310", p1_y, p2_y); failures++; end
        checks++;
        p1_up = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        ticks(1);
        if (p1_y !== 11'd14) begin $display("FAIL p1_down_one: p1_y=%0d want 14", p1_y); failures++; end
        checks++;
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL idle_ball: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
        p1_dn = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_serve_delay;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        p1_dn = 1'b1; p2_dn = 1'b1;
        ticks(11);
        if ({p1_y, p2_y} !== {11'd376, 11'd376}) begin $display("FAIL serve_paddles: got %0d,%0d want 376,376", p1_y, p2_y); failures++; end
        checks++;
        p2_dn = 1'b0; start = 1'b1;
        ticks(48);
        start = 1'b0;
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL serve_hold_59: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL serve_hold_60: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
        if (p1_y !== 11'd612) begin $display("FAIL p1_clamp_bottom: p1_y=%0d want 612", p1_y); failures++; end
        checks++;
        p1_dn = 1'b0;
        ticks(1);
        if ({ball_x, ball_y} !== {11'd639, 11'd359}) begin $display("FAIL serve_first_move: got (%0d,%0d) want (639,359)", ball_x, ball_y); failures++; end
        checks++;
    endtask

    task automatic test_paddle_bounce;
        start = 1'b1;
        ticks(144);
        start = 1'b0;
        if ({ball_x, ball_y} !== {11'd1215, 11'd470}) begin $display("FAIL pre_right_hit: got (%0d,%0d) want (1215,470)", ball_x, ball_y); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y, score_l, score_r} !== {11'd1218, 11'd466, 4'd0, 4'd0}) begin $display("FAIL right_bounce: got (%0d,%0d) %0d/%0d want (1218,466) 0/0", ball_x, ball_y, score_l, score_r); failures++; end
        checks++;
        p2_dn = 1'b1;
        ticks(3);
        p2_dn = 1'b0;
        if ({p2_y, ball_x, ball_y} !== {11'd394, 11'd1206, 11'd454}) begin $display("FAIL after_right_bounce: got p2=%0d (%0d,%0d) want 394 (1206,454)", p2_y, ball_x, ball_y); failures++; end
        checks++;
        ticks(288);
        if ({ball_x, ball_y} !== {11'd54, 11'd694}) begin $display("FAIL pre_left_hit: got (%0d,%0d) want (54,694)", ball_x, ball_y); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y, score_l, score_r} !== {11'd52, 11'd690, 4'd0, 4'd0}) begin $display("FAIL left_bounce: got (%0d,%0d) %0d/%0d want (52,690) 0/0", ball_x, ball_y, score_l, score_r); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y} !== {11'd56, 11'd686}) begin $display("FAIL left_bounce_dx: got (%0d,%0d) want (56,686)", ball_x, ball_y); failures++; end
        checks++;
    endtask

    task automatic test_miss;
        ticks(170);
        if ({ball_x, ball_y} !== {11'd736, 11'd8}) begin $display("FAIL top_wall: got (%0d,%0d) want (736,8)", ball_x, ball_y); failures++; end
        checks++;
        ticks(120);
        ticks(1);
        if ({ball_x, ball_y} !== {11'd1218, 11'd492}) begin $display("FAIL second_right_bounce: got (%0d,%0d) want (1218,492)", ball_x, ball_y); failures++; end
        checks++;
        ticks(302);
        if ({ball_x, ball_y, score_r} !== {11'd10, 11'd308, 4'd0}) begin $display("FAIL pre_left_miss: got (%0d,%0d) r=%0d want (10,308) r=0", ball_x, ball_y, score_r); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y, score_l, score_r, game_over} !== {11'd635, 11'd355, 4'd0, 4'd1, 1'b0}) begin $display("FAIL left_miss: got (%0d,%0d) %0d/%0d go=%0b want (635,355) 0/1 go=0", ball_x, ball_y, score_l, score_r, game_over); failures++; end
        checks++;
        ticks(60);
        ticks(1);
        if ({ball_x, ball_y} !== {11'd631, 11'd359}) begin $display("FAIL miss_serve_dir: got (%0d,%0d) want (631,359)", ball_x, ball_y); failures++; end
        checks++;
    endtask

    task automatic test_reset_mid_play;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        if ({p1_y, p2_y, ball_x, ball_y} !== {11'd310, 11'd310, 11'd635, 11'd355}) begin $display("FAIL mid_reset_pos: got %0d,%0d (%0d,%0d) want 310,310 (635,355)", p1_y, p2_y, ball_x, ball_y); failures++; end
        checks++;
        if ({score_l, score_r, game_over} !== {4'd0, 4'd0, 1'b0}) begin $display("FAIL mid_reset_score: got %0d/%0d go=%0b want 0/0 go=0", score_l, score_r, game_over); failures++; end
        checks++;
        ticks(5);
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL idle_after_reset: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
    endtask

    task automatic test_start_with_tick;
        @(negedge clk); start = 1'b1; frame_tick = 1'b1; p1_dn = 1'b1;
        @(negedge clk); start = 1'b0; frame_tick = 1'b0; p1_dn = 1'b0;
        if ({p1_y, ball_x, ball_y} !== {11'd316, 11'd635, 11'd355}) begin $display("FAIL start_tick: got p1=%0d (%0d,%0d) want 316 (635,355)", p1_y, ball_x, ball_y); failures++; end
        checks++;
        ticks(60);
        if ({ball_x, ball_y} !== {11'd635, 11'd355}) begin $display("FAIL start_tick_serve: got (%0d,%0d) want (635,355)", ball_x, ball_y); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y} !== {11'd639, 11'd359}) begin $display("FAIL start_tick_move: got (%0d,%0d) want (639,359)", ball_x, ball_y); failures++; end
        checks++;
        ticks(155);
        if ({ball_x, ball_y, score_l} !== {11'd1259, 11'd426, 4'd0}) begin $display("FAIL pre_right_miss: got (%0d,%0d) l=%0d want (1259,426) l=0", ball_x, ball_y, score_l); failures++; end
        checks++;
        ticks(1);
        if ({ball_x, ball_y, score_l} !== {11'd635, 11'd355, 4'd1}) begin $display("FAIL right_miss_1: got (%0d,%0d) l=%0d want (635,355) l=1", ball_x, ball_y, score_l); failures++; end
        checks++;
    endtask

    task automatic test_game_over;
        logic [10:0] y_exp;
        for (int r = 2; r <= 9; r++) begin
            // Rallies alternate bottom-wall and top-wall bounces
            y_exp = (r % 2 == 1) ? 11'd426 : 11'd284;
            ticks(216);
            if ({ball_x, ball_y, score_l, game_over} !== {11'd1259, y_exp, 4'(r - 1), 1'b0}) begin $display("FAIL rally_%0d_pre: got (%0d,%0d) l=%0d go=%0b want (1259,%0d) l=%0d go=0", r, ball_x, ball_y, score_l, game_over, y_exp, r - 1); failures++; end
            checks++;
            ticks(1);
            if ({ball_x, ball_y, score_l, score_r, game_over} !== {11'd635, 11'd355, 4'(r), 4'd0, (r == 9)}) begin $display("FAIL rally_%0d_miss: got (%0d,%0d) %0d/%0d go=%0b want (635,355) %0d/0 go=%0b", r, ball_x, ball_y, score_l, score_r, game_over, r, (r == 9)); failures++; end
            checks++;
        end
        p1_up = 1'b1; p2_dn = 1'b1;
        ticks(5);
        p1_up = 1'b0; p2_dn = 1'b0;
        if ({p1_y, p2_y, ball_x, ball_y, score_l, game_over} !== {11'd316, 11'd310, 11'd635, 11'd355, 4'd9, 1'b1}) begin $display("FAIL over_frozen: got %0d,%0d (%0d,%0d) l=%0d go=%0b want 316,310 (635,355) l=9 go=1", p1_y, p2_y, ball_x, ball_y, score_l, game_over); failures++; end
        checks++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if ({score_l, score_r, game_over} !== {4'd0, 4'd0, 1'b0}) begin $display("FAIL restart: got %0d/%0d go=%0b want 0/0 go=0", score_l, score_r, game_over); failures++; end
        checks++;
        ticks(60);
        ticks(1);
        if ({ball_x, ball_y} !== {11'd639, 11'd351}) begin $display("FAIL restart_move: got (%0d,%0d) want (639,351)", ball_x, ball_y); failures++; end
        checks++;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        test_reset;
        test_paddle_clamp;
        test_serve_delay;
        test_paddle_bounce;
        test_miss;
        test_reset_mid_play;
        test_start_with_tick;
        test_game_over;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
